// File: rtl/sin_cos_iq_demodulator.sv
// sin_cos_iq_demodulator: multiplies ADC samples by SIN/COS and dumps windowed I/Q sums with a valid strobe
module sin_cos_iq_demodulator #(
  parameter int ADC_DATA_WIDTH       = 12,
  parameter int SIN_TABLE_DATA_WIDTH = 13,
  parameter int DECIMATION_BITS      = 10,
  parameter int ACC_WIDTH            = 40
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   CE,
  input  logic signed [ADC_DATA_WIDTH-1:0]       ADC_VALUE,
  input  logic signed [SIN_TABLE_DATA_WIDTH-1:0] SIN_VALUE,
  input  logic signed [SIN_TABLE_DATA_WIDTH-1:0] COS_VALUE,
  output logic signed [ACC_WIDTH-1:0]            OUT_I,
  output logic signed [ACC_WIDTH-1:0]            OUT_Q,
  output logic                                   OUT_VALID
);
  localparam int PW = ADC_DATA_WIDTH + SIN_TABLE_DATA_WIDTH;
  logic signed [ADC_DATA_WIDTH-1:0]       adc_q;
  logic signed [SIN_TABLE_DATA_WIDTH-1:0] sin_q, cos_q;
  logic                                   v1_q, v2_q, valid_q, valid_d;
  logic signed [PW-1:0]                   p_i_q, p_q_q, p_i_d, p_q_d;
  logic signed [ACC_WIDTH-1:0]            acc_i_q, acc_q_q, acc_i_d, acc_q_d;
  logic signed [ACC_WIDTH-1:0]            out_i_q, out_q_q, out_i_d, out_q_d;
  logic signed [ACC_WIDTH-1:0]            sum_i, sum_q;
  logic [DECIMATION_BITS-1:0]             cnt_q, cnt_d;
  logic                                   last;
  always_comb begin
    p_i_d   = adc_q * sin_q;
    p_q_d   = adc_q * cos_q;
    sum_i   = acc_i_q + {{(ACC_WIDTH-PW){p_i_q[PW-1]}}, p_i_q};
    sum_q   = acc_q_q + {{(ACC_WIDTH-PW){p_q_q[PW-1]}}, p_q_q};
    // the final product of a window bypasses the accumulator straight into the output
    last    = v2_q && (cnt_q == '1);
    acc_i_d = last ? '0 : v2_q ? sum_i : acc_i_q;
    acc_q_d = last ? '0 : v2_q ? sum_q : acc_q_q;
    cnt_d   = v2_q ? cnt_q + DECIMATION_BITS'(1) : cnt_q;
    out_i_d = last ? sum_i : out_i_q;
    out_q_d = last ? sum_q : out_q_q;
    valid_d = CE && last;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      adc_q   <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      p_i_q   <= '0;
      p_q_q   <= '0;
      acc_i_q <= '0;
      acc_q_q <= '0;
      cnt_q   <= '0;
      out_i_q <= '0;
      out_q_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (CE) begin
        adc_q   <= ADC_VALUE;
        sin_q   <= SIN_VALUE;
        cos_q   <= COS_VALUE;
        v1_q    <= 1'b1;
        v2_q    <= v1_q;
        p_i_q   <= p_i_d;
        p_q_q   <= p_q_d;
        acc_i_q <= acc_i_d;
        acc_q_q <= acc_q_d;
        cnt_q   <= cnt_d;
        out_i_q <= out_i_d;
        out_q_q <= out_q_d;
      end
    end
  end
  assign OUT_I     = out_i_q;
  assign OUT_Q     = out_q_q;
  assign OUT_VALID = valid_q;
endmodule

// File: tb/tb_sin_cos_iq_demodulator.sv
// tb_sin_cos_iq_demodulator: directed checks of windowing, dump timing, CE gaps and reset behaviour
module tb_sin_cos_iq_demodulator;
  logic clk, rst, ce;
  logic signed [11:0] adc;
  logic signed [12:0] sin_v, cos_v;
  logic signed [39:0] i2, q2, i10, q10;
  logic v2, v10;
  int checks = 0;
  int errors = 0;
  sin_cos_iq_demodulator #(.DECIMATION_BITS(2)) u_d2 (
    .CLK(clk), .RESET(rst), .CE(ce), .ADC_VALUE(adc), .SIN_VALUE(sin_v), .COS_VALUE(cos_v),
    .OUT_I(i2), .OUT_Q(q2), .OUT_VALID(v2)
  );
  sin_cos_iq_demodulator u_d10 (
    .CLK(clk), .RESET(rst), .CE(ce), .ADC_VALUE(adc), .SIN_VALUE(sin_v), .COS_VALUE(cos_v),
    .OUT_I(i10), .OUT_Q(q10), .OUT_VALID(v10)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input logic c);
    ce = c;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    int n;
    logic c;
    rst = 1'b1;
    ce = 1'b1;
    adc = '0;
    sin_v = '0;
    cos_v = '0;
    for (int k = 0; k < 4; k++) begin
      adc = 12'($urandom);
      sin_v = 13'($urandom);
      cos_v = 13'($urandom);
      tick(1'b1);
      check("rst_i", i2, 0);
      check("rst_q", q2, 0);
      check("rst_v", v2, 0);
    end
    rst = 1'b0;
    adc = 100; sin_v = 1000; cos_v = -1000;
    for (int k = 0; k < 14; k++) begin
      tick(1'b1);
      check("tone_v", v2, (k == 5 || k == 9 || k == 13));
      if (k == 5 || k == 13) begin
        check("tone_i", i2, 400000);
        check("tone_q", q2, -400000);
      end
    end
    rst = 1'b1;
    #1;
    check("async_i", i2, 0);
    check("async_q", q2, 0);
    check("async_v", v2, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    for (int t = 0; t < 30; t++) begin
      c = (t % 3 == 0);
      tick(c);
      check("gap_v", v2, c && (n == 5 || n == 9));
      if (c && n == 5) begin
        check("gap_i", i2, 400000);
        check("gap_q", q2, -400000);
      end
      if (c) n++;
    end
    pulse_reset();
    sin_v = 10; cos_v = 0;
    for (int k = 0; k < 10; k++) begin
      adc = (k < 4) ? 12'sd1 : (k < 8) ? -12'sd3 : 12'sd0;
      tick(1'b1);
      check("b2b_v", v2, (k == 5 || k == 9));
      if (k == 5) check("b2b_i1", i2, 40);
      if (k == 9) check("b2b_i2", i2, -120);
      if (k == 5 || k == 9) check("b2b_q", q2, 0);
    end
    pulse_reset();
    adc = 50; sin_v = 2; cos_v = 0;
    tick(1'b1);
    tick(1'b1);
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      adc = (k < 4) ? 12'sd7 : 12'sd0;
      sin_v = 3;
      tick(1'b1);
      check("midrst_v", v2, k == 5);
      if (k == 5) check("midrst_i", i2, 84);
    end
    pulse_reset();
    adc = -2048; sin_v = -4096; cos_v = 4095;
    for (int k = 0; k < 1027; k++) begin
      tick(1'b1);
      if (k == 1024 || k == 1025 || k == 1026) check("ext_v", v10, k == 1025);
      if (k == 1025) begin
        check("ext_i", i10, 64'sd8589934592);
        check("ext_q", q10, -64'sd8587837440);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sin_cos_iq_demodulator.md
# sin_cos_iq_demodulator

Quadrature demodulator consuming the sine/cosine stream of the sensor DCO together with ADC samples. Each sample is multiplied by SIN and COS, the products are summed over a fixed window of 2^DECIMATION_BITS samples, and the I/Q sums are dumped once per window with a one-cycle valid strobe. It sits between the DCO/ADC front end and the phase/amplitude post-processing logic. It is the receive-side counterpart of the DCO.

## Interface
- ADC_DATA_WIDTH, 12, width of signed ADC sample
- SIN_TABLE_DATA_WIDTH, 13, width of signed SIN/COS inputs (matches DCO output)
- DECIMATION_BITS, 10, window length N = 2^DECIMATION_BITS samples; legal range 1..16
- ACC_WIDTH, 40, accumulator/output width; must be >= ADC_DATA_WIDTH + SIN_TABLE_DATA_WIDTH + DECIMATION_BITS

Ports:
- CLK  in  1  clock; single clock domain
- RESET  in  1  asynchronous, active-high reset
- CE  in  1  clock enable; one sample consumed per CLK edge with CE=1; CE=0 freezes pipeline, counter and accumulators
- ADC_VALUE  in  ADC_DATA_WIDTH  signed two's-complement ADC sample
- SIN_VALUE  in  SIN_TABLE_DATA_WIDTH  signed sine reference, time-aligned with ADC_VALUE by the caller
- COS_VALUE  in  SIN_TABLE_DATA_WIDTH  signed cosine reference, time-aligned with ADC_VALUE by the caller
- OUT_I  out  ACC_WIDTH  signed sum of ADC*SIN over the last completed window
- OUT_Q  out  ACC_WIDTH  signed sum of ADC*COS over the last completed window
- OUT_VALID  out  1  one-CLK pulse; OUT_I/OUT_Q updated on the same edge

## Operation
- Stage 1, on CE: register ADC_VALUE, SIN_VALUE, COS_VALUE; set v1 <= 1.
- Stage 2, on CE: signed products p_i = adc*sin and p_q = adc*cos, each ADC_DATA_WIDTH+SIN_TABLE_DATA_WIDTH bits; set v2 <= v1.
- Stage 3, on CE with v2=1: sign-extend the products to ACC_WIDTH and add them to acc_i/acc_q. Also increment the window counter cnt (DECIMATION_BITS bits).
- Dump: on a stage-3 update where cnt == N-1:
  - OUT_I <= acc_i + p_i and OUT_Q <= acc_q + p_q;
  - acc_i/acc_q <= 0;
  - cnt wraps to 0;
  - OUT_VALID <= 1.
  - The next product starts a fresh window. There is no carry between windows and no sample is dropped.
- Stages with v=0 (pipeline fill after reset) do not accumulate and do not count.
- Arithmetic is two's complement, wrapping modulo 2^ACC_WIDTH. The parameter constraint makes overflow impossible, so no saturation logic exists.
- OUT_I/OUT_Q hold their value between dumps.
- Reset (asynchronous, any time, including mid-window) clears to 0: all pipeline registers, v1, v2, cnt, acc_i, acc_q, OUT_I, OUT_Q, OUT_VALID. The first window after reset contains only post-reset samples.

## Timing
- Reset values: OUT_I=0, OUT_Q=0, OUT_VALID=0.
- Sample latency is 3 CE edges. A sample captured on CE edge k reaches the accumulator on CE edge k+2.
- Counting CE edges k=0,1,... after reset release, the first dump occurs on CE edge N+1. Subsequent dumps occur every N CE edges.
- OUT_VALID is high for exactly one CLK cycle after the dump edge. It clears on the next CLK edge regardless of CE.
- CE=0 cycles insert no samples; window content depends only on CE=1 samples.
- The DCO SIN/COS alignment with ADC is the caller's responsibility. This block adds no alignment delay.

## Test plan
- Reset: hold RESET with random inputs and CE=1 -> OUT_I=OUT_Q=0, OUT_VALID=0 throughout. Release, then apply async RESET between edges -> outputs clear immediately.
- Constant tone, DECIMATION_BITS=2: ADC=100, SIN=1000, COS=-1000, CE=1 -> OUT_VALID pulses after CE edge 5, then after edges 9, 13, ...; OUT_I=400000, OUT_Q=-400000.
- Extremes at defaults: ADC=-2048, SIN=-4096, COS=4095 for 1024 samples -> OUT_I=8589934592 (2^33), OUT_Q=-8587837440; no wrap.
- CE gaps, DECIMATION_BITS=2: same stimulus as the constant-tone case with CE=1 every third cycle -> identical OUT_I/OUT_Q; OUT_VALID exactly one CLK wide; dump after the 6th CE edge.
- Back-to-back windows, DECIMATION_BITS=2: ADC=1 for 4 samples then ADC=-3 for 4 samples, SIN=10, COS=0 -> first dump OUT_I=40, second dump OUT_I=-120, OUT_Q=0 both times.
- Reset mid-window, DECIMATION_BITS=2: 2 samples of ADC=50, SIN=2, then RESET pulse, then 4 samples of ADC=7, SIN=3 -> first dump after release shows OUT_I=84.
